// File: rtl/ieu_fwd.sv
// ieu_fwd -- integer execution unit with operand forwarding.
//
// Decodes and executes one RV32I-style instruction per cycle and tracks
// in-flight writebacks in a WB_DELAY-deep result pipeline.
// RAW hazards are resolved by forwarding from that pipeline.
// Only load-use hazards stall, or every RAW hit when FORWARD=0.
//
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   stall             external stall: instruction not issued this cycle
//   instr             instruction bits [31:2]
//   curr_pc, inc_pc   PC and PC+4 of instr
//   mem_rdata         load data, valid while the load sits in the last stage
//   stalled           fetch must hold (stall, hazard or reset)
//   je, ja            jump/branch taken and its target
//   funct3            memory access size/sign
//   result            ALU result, inc_pc for jumps, address for loads/stores
//   reg_out           forwarded rs2 value (store data)
//   mm_we, mm_re      store enable / load request
//   hazard_cnt        saturating count of hazard-stall cycles
module ieu_fwd #(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned WB_DELAY = 2,
    parameter bit          FORWARD  = 1'b1,
    parameter int unsigned CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall,
    input  logic [29:0]      instr,
    input  logic [XLEN-1:0]  curr_pc,
    input  logic [XLEN-1:0]  inc_pc,
    input  logic [XLEN-1:0]  mem_rdata,
    output logic             stalled,
    output logic             je,
    output logic [XLEN-1:0]  ja,
    output logic [2:0]       funct3,
    output logic [XLEN-1:0]  result,
    output logic [XLEN-1:0]  reg_out,
    output logic             mm_we,
    output logic             mm_re,
    output logic [CNT_W-1:0] hazard_cnt
);

    typedef enum logic [4:0] {
        OPC_LOAD   = 5'b00000,
        OPC_OPIMM  = 5'b00100,
        OPC_AUIPC  = 5'b00101,
        OPC_STORE  = 5'b01000,
        OPC_OP     = 5'b01100,
        OPC_LUI    = 5'b01101,
        OPC_BRANCH = 5'b11000,
        OPC_JALR   = 5'b11001,
        OPC_JAL    = 5'b11011
    } opcode_e;

    typedef enum logic [1:0] {
        ASRC_RS1,
        ASRC_PC,
        ASRC_ZERO
    } asrc_e;

    // Instruction fields, indexed with their architectural bit numbers.
    logic [31:2] ins;
    opcode_e     opc;
    logic [4:0]  rd;
    logic [2:0]  f3;
    logic signed [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

    assign ins   = instr;
    assign opc   = opcode_e'(ins[6:2]);
    assign rd    = ins[11:7];
    assign f3    = ins[14:12];
    assign imm_i = {{20{ins[31]}}, ins[31:20]};
    assign imm_s = {{20{ins[31]}}, ins[31:25], ins[11:7]};
    assign imm_b = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
    assign imm_u = {ins[31:12], 12'b0};
    assign imm_j = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};

    // Decoder outputs
    logic        rd_we, is_load, is_store, is_branch, is_jump, b_imm;
    logic        use_rs [2];
    asrc_e       a_src;
    logic signed [31:0] imm;
    logic [2:0]  alu_f3;
    logic        alu_alt;

    always_comb begin
        rd_we     = 1'b0;
        is_load   = 1'b0;
        is_store  = 1'b0;
        is_branch = 1'b0;
        is_jump   = 1'b0;
        b_imm     = 1'b0;
        use_rs[0] = 1'b0;
        use_rs[1] = 1'b0;
        a_src     = ASRC_RS1;
        imm       = imm_i;
        alu_f3    = 3'b000;
        alu_alt   = 1'b0;
        unique case (opc)
            OPC_LUI:    begin rd_we = 1'b1; a_src = ASRC_ZERO; b_imm = 1'b1; imm = imm_u; end
            OPC_AUIPC:  begin rd_we = 1'b1; a_src = ASRC_PC;   b_imm = 1'b1; imm = imm_u; end
            OPC_JAL:    begin rd_we = 1'b1; is_jump = 1'b1; a_src = ASRC_PC; b_imm = 1'b1; imm = imm_j; end
            OPC_JALR:   begin rd_we = 1'b1; is_jump = 1'b1; use_rs[0] = 1'b1; b_imm = 1'b1; end
            OPC_BRANCH: begin
                is_branch = 1'b1; use_rs[0] = 1'b1; use_rs[1] = 1'b1;
                a_src = ASRC_PC; b_imm = 1'b1; imm = imm_b;
            end
            OPC_LOAD:   begin rd_we = 1'b1; is_load = 1'b1; use_rs[0] = 1'b1; b_imm = 1'b1; end
            OPC_STORE:  begin
                is_store = 1'b1; use_rs[0] = 1'b1; use_rs[1] = 1'b1;
                b_imm = 1'b1; imm = imm_s;
            end
            OPC_OPIMM:  begin
                rd_we = 1'b1; use_rs[0] = 1'b1; b_imm = 1'b1;
                alu_f3 = f3; alu_alt = (f3 == 3'b101) && ins[30];
            end
            OPC_OP:     begin
                rd_we = 1'b1; use_rs[0] = 1'b1; use_rs[1] = 1'b1;
                alu_f3 = f3; alu_alt = ins[30];
            end
            default: ;
        endcase
    end

    // Result pipeline, stage 1 youngest
    logic            st_valid_q [1:WB_DELAY], st_valid_d [1:WB_DELAY];
    logic            st_load_q  [1:WB_DELAY], st_load_d  [1:WB_DELAY];
    logic [4:0]      st_rd_q    [1:WB_DELAY], st_rd_d    [1:WB_DELAY];
    logic [XLEN-1:0] st_data_q  [1:WB_DELAY], st_data_d  [1:WB_DELAY];
    logic [XLEN-1:0] rf_q [32];
    logic [CNT_W-1:0] hazard_cnt_q, hazard_cnt_d;

    // Operand resolution: the first hit scanning from stage 1 is the youngest writer.
    logic [4:0]      rs_addr [2];
    logic [XLEN-1:0] op_val  [2];
    logic            rs_haz  [2];
    logic            rs_hit  [2];

    assign rs_addr[0] = ins[19:15];
    assign rs_addr[1] = ins[24:20];

    always_comb begin
        for (int unsigned j = 0; j < 2; j++) begin
            op_val[j] = '0;
            rs_haz[j] = 1'b0;
            rs_hit[j] = 1'b0;
            if (rs_addr[j] != 5'd0) begin
                op_val[j] = rf_q[rs_addr[j]];
                for (int unsigned i = 1; i <= WB_DELAY; i++) begin
                    if (!rs_hit[j] && st_valid_q[i] && st_rd_q[i] == rs_addr[j]) begin
                        rs_hit[j] = 1'b1;
                        if (!FORWARD) begin
                            rs_haz[j] = 1'b1;
                        end else if (st_load_q[i]) begin
                            if (i < WB_DELAY) rs_haz[j] = 1'b1;
                            else              op_val[j] = mem_rdata;
                        end else begin
                            op_val[j] = st_data_q[i];
                        end
                    end
                end
            end
        end
    end

    // ALU
    logic [XLEN-1:0] alu_a, alu_b, alu_res;
    logic [4:0]      shamt;
    logic            br_taken;

    always_comb begin
        unique case (a_src)
            ASRC_PC:   alu_a = curr_pc;
            ASRC_ZERO: alu_a = '0;
            default:   alu_a = op_val[0];
        endcase
        alu_b = b_imm ? XLEN'(imm) : op_val[1];
        shamt = alu_b[4:0];
        unique case (alu_f3)
            3'b000:  alu_res = alu_alt ? alu_a - alu_b : alu_a + alu_b;
            3'b001:  alu_res = alu_a << shamt;
            3'b010:  alu_res = XLEN'($signed(alu_a) < $signed(alu_b));
            3'b011:  alu_res = XLEN'(alu_a < alu_b);
            3'b100:  alu_res = alu_a ^ alu_b;
            3'b101:  alu_res = alu_alt ? XLEN'($signed(alu_a) >>> shamt) : alu_a >> shamt;
            3'b110:  alu_res = alu_a | alu_b;
            default: alu_res = alu_a & alu_b;
        endcase
    end

    // Branch condition compares the two register operands.
    always_comb begin
        unique case (f3)
            3'b000:  br_taken = op_val[0] == op_val[1];
            3'b001:  br_taken = op_val[0] != op_val[1];
            3'b100:  br_taken = $signed(op_val[0]) <  $signed(op_val[1]);
            3'b101:  br_taken = $signed(op_val[0]) >= $signed(op_val[1]);
            3'b110:  br_taken = op_val[0] <  op_val[1];
            3'b111:  br_taken = op_val[0] >= op_val[1];
            default: br_taken = 1'b0;
        endcase
    end

    logic hazard, issue;

    assign hazard  = (use_rs[0] && rs_haz[0]) || (use_rs[1] && rs_haz[1]);
    assign stalled = stall || hazard || !rst_n;
    assign issue   = !stalled;

    assign je         = issue && (is_jump || (is_branch && br_taken));
    assign ja         = alu_res;
    assign funct3     = f3;
    assign result     = is_jump ? inc_pc : alu_res;
    assign reg_out    = op_val[1];
    assign mm_we      = issue && is_store;
    assign mm_re      = issue && is_load;
    assign hazard_cnt = hazard_cnt_q;

    always_comb begin
        st_valid_d[1] = issue && rd_we && (rd != 5'd0);
        st_load_d[1]  = is_load;
        st_rd_d[1]    = rd;
        st_data_d[1]  = result;
        for (int unsigned i = 2; i <= WB_DELAY; i++) begin
            st_valid_d[i] = st_valid_q[i-1];
            st_load_d[i]  = st_load_q[i-1];
            st_rd_d[i]    = st_rd_q[i-1];
            st_data_d[i]  = st_data_q[i-1];
        end
    end

    // An external stall masks the hazard for counting purposes.
    always_comb begin
        hazard_cnt_d = hazard_cnt_q;
        if (hazard && !stall && hazard_cnt_q != '1)
            hazard_cnt_d = hazard_cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        for (int unsigned i = 1; i <= WB_DELAY; i++) begin
            st_valid_q[i] <= rst_n ? st_valid_d[i] : 1'b0;
            st_load_q[i]  <= st_load_d[i];
            st_rd_q[i]    <= st_rd_d[i];
            st_data_q[i]  <= st_data_d[i];
        end
        if (!rst_n) hazard_cnt_q <= '0;
        else        hazard_cnt_q <= hazard_cnt_d;
    end

    // Register file write from the last stage; contents are never reset.
    logic            wb_we;
    logic [XLEN-1:0] wb_data;

    assign wb_we   = rst_n && st_valid_q[WB_DELAY];
    assign wb_data = st_load_q[WB_DELAY] ? mem_rdata : st_data_q[WB_DELAY];

    always_ff @(posedge clk) begin
        if (wb_we) rf_q[st_rd_q[WB_DELAY]] <= wb_data;
    end

endmodule

// File: tb/tb_ieu_fwd.sv
module tb_ieu_fwd;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall, stall0;
    logic [29:0] instr, instr0;
    logic [31:0] curr_pc, inc_pc, mem_rdata;
    logic        stalled, je, mm_we, mm_re;
    logic [31:0] ja, result, reg_out, hazard_cnt;
    logic [2:0]  funct3;
    logic        stalled0, je0, mm_we0, mm_re0;
    logic [31:0] ja0, result0, reg_out0, hazard_cnt0;
    logic [2:0]  funct30;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    ieu_fwd #(.XLEN(32), .WB_DELAY(2), .FORWARD(1'b1), .CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .instr(instr),
        .curr_pc(curr_pc), .inc_pc(inc_pc), .mem_rdata(mem_rdata),
        .stalled(stalled), .je(je), .ja(ja), .funct3(funct3),
        .result(result), .reg_out(reg_out), .mm_we(mm_we), .mm_re(mm_re),
        .hazard_cnt(hazard_cnt)
    );

    ieu_fwd #(.XLEN(32), .WB_DELAY(2), .FORWARD(1'b0), .CNT_W(32)) dut0 (
        .clk(clk), .rst_n(rst_n), .stall(stall0), .instr(instr0),
        .curr_pc(curr_pc), .inc_pc(inc_pc), .mem_rdata(mem_rdata),
        .stalled(stalled0), .je(je0), .ja(ja0), .funct3(funct30),
        .result(result0), .reg_out(reg_out0), .mm_we(mm_we0), .mm_re(mm_re0),
        .hazard_cnt(hazard_cnt0)
    );

    function automatic logic [31:0] addi(input logic [4:0] rd, input logic [4:0] rs1, input logic [11:0] imm);
        return {imm, rs1, 3'b000, rd, 7'h13};
    endfunction
    function automatic logic [31:0] add(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
        return {7'b0, rs2, rs1, 3'b000, rd, 7'h33};
    endfunction
    function automatic logic [31:0] lw(input logic [4:0] rd, input logic [4:0] rs1, input logic [11:0] imm);
        return {imm, rs1, 3'b010, rd, 7'h03};
    endfunction
    function automatic logic [31:0] sw(input logic [4:0] rs2, input logic [4:0] rs1, input logic [11:0] imm);
        return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'h23};
    endfunction
    function automatic logic [31:0] beq(input logic [4:0] rs1, input logic [4:0] rs2, input logic [12:0] imm);
        return {imm[12], imm[10:5], rs2, rs1, 3'b000, imm[4:1], imm[11], 7'h63};
    endfunction

    // One record per clock cycle. chk: 0 = no datapath check, 1 = result, 2 = ja.
    typedef struct {
        logic        rst_n;
        logic        stall;
        logic [31:0] ins;
        logic [31:0] mrd;
        logic        e_stl, e_je, e_we, e_re;
        logic [1:0]  chk;
        logic [31:0] e_val;
        logic [31:0] e_hc;
    } vec_t;

    function automatic vec_t mk(input logic r, input logic s, input logic [31:0] ins,
                                input logic [31:0] mrd, input logic es, input logic ej,
                                input logic ew, input logic er, input logic [1:0] chk,
                                input logic [31:0] ev, input logic [31:0] ehc);
        vec_t v;
        v.rst_n = r; v.stall = s; v.ins = ins; v.mrd = mrd;
        v.e_stl = es; v.e_je = ej; v.e_we = ew; v.e_re = er;
        v.chk = chk; v.e_val = ev; v.e_hc = ehc;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual=%h expected=%h", name, act, exp);
        end
    endtask

    vec_t vt[$];
    logic [31:0] nop;
    logic [31:0] tmp;
    int stall_cycles;

    initial begin
        nop = addi(5'd0, 5'd0, 12'd0);
        // Forwarding back-to-back, load-use, youngest-wins, x0, stall masking, reset.
        vt.push_back(mk(1,0,addi(1,0,5),     0,      0,0,0,0, 1,32'd5,     0)); // 0
        vt.push_back(mk(1,0,add(2,1,1),      0,      0,0,0,0, 1,32'd10,    0)); // 1
        vt.push_back(mk(1,0,nop,             0,      0,0,0,0, 0,0,         0)); // 2
        vt.push_back(mk(1,0,nop,             0,      0,0,0,0, 0,0,         0)); // 3
        vt.push_back(mk(1,0,add(6,2,0),      0,      0,0,0,0, 1,32'd10,    0)); // 4
        vt.push_back(mk(1,0,lw(3,0,0),       0,      0,0,0,1, 1,32'd0,     0)); // 5
        vt.push_back(mk(1,0,addi(4,3,1),     0,      1,0,0,0, 0,0,         0)); // 6
        vt.push_back(mk(1,0,addi(4,3,1),     32'h1234,0,0,0,0, 1,32'h1235, 1)); // 7
        vt.push_back(mk(1,0,nop,             0,      0,0,0,0, 0,0,         1)); // 8
        vt.push_back(mk(1,0,addi(5,0,1),     0,      0,0,0,0, 1,32'd1,     1)); // 9
        vt.push_back(mk(1,0,addi(5,0,2),     0,      0,0,0,0, 1,32'd2,     1)); // 10
        vt.push_back(mk(1,0,add(7,5,0),      0,      0,0,0,0, 1,32'd2,     1)); // 11
        vt.push_back(mk(1,0,addi(0,0,9),     0,      0,0,0,0, 1,32'd9,     1)); // 12
        vt.push_back(mk(1,0,add(8,0,0),      0,      0,0,0,0, 1,32'd0,     1)); // 13
        vt.push_back(mk(1,0,addi(9,3,0),     0,      0,0,0,0, 1,32'h1234,  1)); // 14
        vt.push_back(mk(1,1,sw(1,0,4),       0,      1,0,0,0, 0,0,         1)); // 15
        vt.push_back(mk(1,0,sw(1,0,4),       0,      0,0,1,0, 1,32'd4,     1)); // 16
        vt.push_back(mk(1,1,beq(1,1,8),      0,      1,0,0,0, 0,0,         1)); // 17
        vt.push_back(mk(1,0,beq(1,1,8),      0,      0,1,0,0, 2,32'h108,   1)); // 18
        vt.push_back(mk(1,1,addi(1,0,77),    0,      1,0,0,0, 0,0,         1)); // 19
        vt.push_back(mk(1,0,nop,             0,      0,0,0,0, 0,0,         1)); // 20
        vt.push_back(mk(1,0,nop,             0,      0,0,0,0, 0,0,         1)); // 21
        vt.push_back(mk(1,0,add(10,1,0),     0,      0,0,0,0, 1,32'd5,     1)); // 22
        vt.push_back(mk(1,0,lw(11,0,0),      0,      0,0,0,1, 0,0,         1)); // 23
        vt.push_back(mk(1,1,addi(12,11,0),   0,      1,0,0,0, 0,0,         1)); // 24
        vt.push_back(mk(1,0,nop,             0,      0,0,0,0, 0,0,         1)); // 25
        vt.push_back(mk(1,0,lw(3,0,0),       0,      0,0,0,1, 0,0,         1)); // 26
        vt.push_back(mk(0,0,lw(3,0,0),       32'hDEAD,1,0,0,0, 0,0,        1)); // 27
        vt.push_back(mk(1,0,nop,             32'hDEAD,0,0,0,0, 0,0,        0)); // 28
        vt.push_back(mk(1,0,nop,             0,      0,0,0,0, 0,0,         0)); // 29
        vt.push_back(mk(1,0,addi(13,3,0),    0,      0,0,0,0, 1,32'h1234,  0)); // 30

        rst_n = 1'b0; stall = 1'b0; stall0 = 1'b0;
        instr = nop[31:2]; instr0 = nop[31:2];
        curr_pc = 32'h100; inc_pc = 32'h104; mem_rdata = '0;
        repeat (2) @(posedge clk);
        #1;

        for (int k = 0; k < vt.size(); k++) begin
            rst_n     = vt[k].rst_n;
            stall     = vt[k].stall;
            tmp       = vt[k].ins;
            instr     = tmp[31:2];
            mem_rdata = vt[k].mrd;
            #4;
            check($sformatf("v%0d.stalled", k), {31'b0, stalled}, {31'b0, vt[k].e_stl});
            check($sformatf("v%0d.je", k),      {31'b0, je},      {31'b0, vt[k].e_je});
            check($sformatf("v%0d.mm_we", k),   {31'b0, mm_we},   {31'b0, vt[k].e_we});
            check($sformatf("v%0d.mm_re", k),   {31'b0, mm_re},   {31'b0, vt[k].e_re});
            check($sformatf("v%0d.hazard_cnt", k), hazard_cnt, vt[k].e_hc);
            if (vt[k].chk == 2'd1) check($sformatf("v%0d.result", k), result, vt[k].e_val);
            if (vt[k].chk == 2'd2) check($sformatf("v%0d.ja", k),     ja,     vt[k].e_val);
            @(posedge clk);
            #1;
        end

        // FORWARD=0 instance: RAW on an ALU result stalls until writeback.
        stall = 1'b0; instr = nop[31:2]; mem_rdata = '0;
        tmp = addi(1, 0, 7);
        instr0 = tmp[31:2];
        #4;
        check("nf.first_stalled", {31'b0, stalled0}, 32'd0);
        check("nf.first_result", result0, 32'd7);
        @(posedge clk);
        #1;
        tmp = addi(2, 1, 0);
        instr0 = tmp[31:2];
        stall_cycles = 0;
        for (int k = 0; k < 8; k++) begin
            #4;
            if (!stalled0) break;
            stall_cycles++;
            @(posedge clk);
            #1;
        end
        check("nf.stall_cycles", stall_cycles, 32'd2);
        check("nf.result", result0, 32'd7);
        check("nf.hazard_cnt", hazard_cnt0, 32'd2);
        check("nf.fwd_dut_hazard_cnt", hazard_cnt, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
